// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//
// Boot-time program loader placed in front of the CPU program memory.
// It receives a framed byte stream (MAGIC, LEN, LEN payload bytes, CHK),
// writes the payload into program memory from address 0 upwards, verifies
// the 8-bit checksum and then enables the CPU.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream byte valid
//   in_data    : upstream byte
//   in_ready   : loader accepts a byte this cycle (low only while running)
//   reload     : single-cycle pulse; while running, returns to idle
//   mem_we     : program memory write enable (registered)
//   mem_addr   : program memory write address (registered)
//   mem_wdata  : program memory write data (registered)
//   cpu_run    : CPU enable, high only after a frame with a good checksum
//   load_done  : one-cycle pulse when the CPU is released
//   chk_err    : sticky flag, last frame failed its checksum
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter logic [7:0] MAGIC  = 8'hA5,
    parameter int          ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    input  logic              reload,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_run,
    output logic              load_done,
    output logic              chk_err
);

    // One extra bit so the counter can hold a full 2^ADDR_W byte payload.
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LENGTH,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_sum;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_transfer;
    logic                w_is_magic;
    logic [CNT_W-1:0]    w_len;
    logic [7:0]          w_sum_next;

    assign in_ready   = (r_state != S_RUN);
    assign w_transfer = in_valid && in_ready;
    assign w_is_magic = (in_data == MAGIC);
    // A length byte of zero encodes the largest possible payload.
    assign w_len      = (in_data == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(in_data);
    // Running sum including the byte on the bus; used for data and checksum.
    assign w_sum_next = r_sum + in_data;

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_sum     <= '0;
            r_addr    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_run   <= 1'b0;
            load_done <= 1'b0;
            chk_err   <= 1'b0;
        end else begin
            // NOTE: pulse outputs get a default low here so each assertion
            // below lasts exactly one cycle without extra clearing logic.
            mem_we    <= 1'b0;
            load_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    // Non-MAGIC bytes are accepted and dropped.
                    if (w_transfer && w_is_magic) r_state <= S_LENGTH;
                end

                S_LENGTH: begin
                    if (w_transfer) begin
                        r_count <= w_len;
                        r_sum   <= '0;
                        r_addr  <= '0;
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    if (w_transfer) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_addr;
                        mem_wdata <= in_data;
                        // Wraps to 0 after a full-size payload; harmless since
                        // no further write follows in this frame.
                        r_addr    <= r_addr + ADDR_W'(1);
                        r_sum     <= w_sum_next;
                        r_count   <= r_count - CNT_W'(1);
                        if (r_count == CNT_W'(1)) r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (w_transfer) begin
                        if (w_sum_next == 8'd0) begin
                            r_state   <= S_RUN;
                            cpu_run   <= 1'b1;
                            load_done <= 1'b1;
                            chk_err   <= 1'b0;
                        end else begin
                            r_state   <= S_ERR;
                            chk_err   <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (reload) begin
                        r_state <= S_IDLE;
                        cpu_run <= 1'b0;
                    end
                end

                S_ERR: begin
                    // Only a fresh MAGIC restarts loading and clears the error.
                    if (w_transfer && w_is_magic) begin
                        r_state <= S_LENGTH;
                        chk_err <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//
// Self-checking bench for prog_loader. The driver sends whole frames and,
// knowing what each byte means, predicts at frame level the memory writes
// (address = payload index) and the run/error outcome (checksum arithmetic).
// A per-cycle monitor compares every DUT output against that prediction;
// literal expectations after each scenario pin the prediction itself.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam logic [7:0] MAGIC = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       reload;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_run;
    logic       load_done;
    logic       chk_err;

    prog_loader #(.MAGIC(MAGIC), .ADDR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_run   (cpu_run),
        .load_done (load_done),
        .chk_err   (chk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_writes = 0;
    int  cyc      = 0;

    // Frame-level reference model
    wr_t        exp_q[$];
    wr_t        m_last;
    logic       m_run;
    logic       m_err;
    int         m_done_cycle;

    logic [7:0] pl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last       = '{addr: 8'h00, data: 8'h00};
        m_run        = 1'b0;
        m_err        = 1'b0;
        m_done_cycle = -1;
    endtask

    always @(posedge clk) cyc++;

    // Per-cycle monitor, sampled half a period away from the active edge.
    always @(negedge clk) begin
        check("cpu_run",   cpu_run,   m_run);
        check("chk_err",   chk_err,   m_err);
        check("load_done", load_done, cyc == m_done_cycle);
        check("in_ready",  in_ready,  !m_run);
        check("mem_we",    mem_we,    exp_q.size() != 0);
        if (mem_we && exp_q.size() != 0) begin
            m_last = exp_q.pop_front();
            n_writes++;
        end
        check("mem_addr",  mem_addr,  m_last.addr);
        check("mem_wdata", mem_wdata, m_last.data);
    end

    // Drive one byte after 'gap' idle cycles (with junk on the data bus) and
    // return 1 ns after the edge on which it transferred.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_wait", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] len, input logic [7:0] payload[$],
                              input logic [7:0] chk, input int gap);
        logic [7:0] sum;
        send_byte(MAGIC, gap);
        m_err = 1'b0;
        send_byte(len, gap);
        sum = 8'h00;
        foreach (payload[i]) begin
            send_byte(payload[i], gap);
            exp_q.push_back('{addr: 8'(i), data: payload[i]});
            sum = sum + payload[i];
        end
        send_byte(chk, gap);
        sum = sum + chk;
        m_run = (sum == 8'h00);
        m_err = (sum != 8'h00);
        if (sum == 8'h00) m_done_cycle = cyc;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        m_run  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;
        model_reset();
        #3;
        check("rst_mem_we",    mem_we,    1'b0);
        check("rst_mem_addr",  mem_addr,  8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_cpu_run",   cpu_run,   1'b0);
        check("rst_load_done", load_done, 1'b0);
        check("rst_chk_err",   chk_err,   1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        idle(2);
        #2 rst_n = 1'b1;
        idle(2);
        check("post_rst_in_ready", in_ready, 1'b1);

        // 2: good frame back-to-back
        n_writes = 0;
        pl = {8'h20, 8'h41, 8'h7F};
        send_frame(8'h03, pl, 8'h20, 0);
        check("t2_cpu_run",   cpu_run,   1'b1);
        check("t2_load_done", load_done, 1'b1);
        check("t2_chk_err",   chk_err,   1'b0);
        check("t2_in_ready",  in_ready,  1'b0);
        check("t2_writes",    n_writes,  3);
        check("t2_last_addr", mem_addr,  8'h02);
        check("t2_last_data", mem_wdata, 8'h7F);
        idle(1);
        check("t2_done_pulse_end", load_done, 1'b0);
        // Bytes offered while running must be refused and have no effect.
        in_valid = 1'b1;
        in_data  = MAGIC;
        idle(3);
        in_valid = 1'b0;
        check("t2_run_hold", cpu_run, 1'b1);
        pulse_reload();

        // 3: bad checksum, reload ignored in ERR, then recovery frame
        n_writes = 0;
        pl = {8'h20, 8'h41, 8'h7F};
        send_frame(8'h03, pl, 8'h21, 0);
        check("t3_chk_err", chk_err,  1'b1);
        check("t3_cpu_run", cpu_run,  1'b0);
        check("t3_writes",  n_writes, 3);
        reload = 1'b1;
        idle(1);
        reload = 1'b0;
        idle(1);
        check("t3_err_sticky", chk_err, 1'b1);
        pl = {8'h05};
        send_frame(8'h01, pl, 8'hFB, 0);
        check("t3_recover_run",  cpu_run,   1'b1);
        check("t3_recover_err",  chk_err,   1'b0);
        check("t3_recover_addr", mem_addr,  8'h00);
        check("t3_recover_data", mem_wdata, 8'h05);
        pulse_reload();

        // 4: leading garbage and 3-cycle gaps between all bytes
        n_writes = 0;
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        send_byte(8'h13, 3);
        pl = {8'hAA};
        send_frame(8'h01, pl, 8'h56, 3);
        check("t4_writes",  n_writes,  1);
        check("t4_data",    mem_wdata, 8'hAA);
        check("t4_cpu_run", cpu_run,   1'b1);
        pulse_reload();

        // 5: LEN=0 means 256 bytes, address wraps after the last write
        n_writes = 0;
        pl.delete();
        repeat (256) pl.push_back(8'h01);
        send_frame(8'h00, pl, 8'h00, 0);
        check("t5_writes",    n_writes, 256);
        check("t5_last_addr", mem_addr, 8'hFF);
        check("t5_cpu_run",   cpu_run,  1'b1);
        idle(2);
        pulse_reload();
        idle(1);
        check("t5_reload_run",   cpu_run,  1'b0);
        check("t5_reload_ready", in_ready, 1'b1);

        // 6: reset in the middle of a frame, then a clean load
        n_writes = 0;
        send_byte(MAGIC, 0);
        send_byte(8'h04, 0);
        send_byte(8'h11, 0);
        exp_q.push_back('{addr: 8'h00, data: 8'h11});
        send_byte(8'h22, 0);
        exp_q.push_back('{addr: 8'h01, data: 8'h22});
        idle(1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_addr",  mem_addr,  8'h00);
        check("t6_rst_data",  mem_wdata, 8'h00);
        check("t6_rst_ready", in_ready,  1'b1);
        idle(2);
        #2 rst_n = 1'b1;
        idle(3);
        check("t6_partial_writes", n_writes, 2);
        pl = {8'h33};
        send_frame(8'h01, pl, 8'hCD, 0);
        check("t6_cpu_run", cpu_run,   1'b1);
        check("t6_data",    mem_wdata, 8'h33);
        check("t6_writes",  n_writes,  3);
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time program loader that sits directly upstream of the 8-bit CPU's program memory.
- Accepts a framed byte stream over a valid/ready handshake and writes the payload into program memory starting at address 0.
- Validates an 8-bit checksum, then releases the CPU via cpu_run.
- The CPU core treats cpu_run as its enable: PC and accumulator are held while it is low.

Parameters:
- MAGIC, 8'hA5, start-of-frame byte
- ADDR_W, 8, program memory address width; payload length field spans 1..2^ADDR_W

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream byte valid
- in_data  input  8  upstream byte
- in_ready  output  1  loader can accept a byte this cycle
- reload  input  1  single-cycle pulse; in RUN, returns to IDLE and drops cpu_run
- mem_we  output  1  program memory write enable, registered
- mem_addr  output  ADDR_W  program memory write address, registered
- mem_wdata  output  8  program memory write data, registered
- cpu_run  output  1  CPU enable, high only after a good frame
- load_done  output  1  one-cycle pulse on entry to RUN
- chk_err  output  1  sticky: last frame failed checksum

Behaviour:
- Reset clock and port names: clock is clk; reset is rst_n, asynchronous, active-low.
- Reset (async assert, any state): state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, load_done=0, chk_err=0, in_ready=1, internal count=0, sum=0.
- A transfer occurs on a rising clk edge with in_valid && in_ready. in_data is sampled only on transfer.
- Frame format: MAGIC, LEN, LEN payload bytes, CHK.
  - LEN=0 means 256 bytes.
  - Frame is good when (sum of payload + CHK) mod 256 == 0.
- State machine (in_ready is combinational from state):
  - IDLE (in_ready=1): transfer of MAGIC -> LENGTH; any other byte is discarded.
  - LENGTH (in_ready=1): transfer latches count=LEN, clears sum and address -> DATA.
  - DATA (in_ready=1): each transfer:
    - next cycle mem_we=1, mem_addr=current address, mem_wdata=byte;
    - address+1, sum+=byte mod 256, count-1.
    - After the last byte -> CHECK.
  - CHECK (in_ready=1): transfer evaluates the checksum.
    - Good: -> RUN, cpu_run=1 from the next cycle, load_done pulses 1 cycle, chk_err=0.
    - Bad: -> ERR, chk_err=1.
  - RUN (in_ready=0): cpu_run=1. reload=1 -> IDLE with cpu_run=0 next cycle. reload is ignored in all other states.
  - ERR (in_ready=1): cpu_run=0, chk_err held. MAGIC transfer -> LENGTH and clears chk_err; other bytes are discarded.
- mem_we:
  - Asserted exactly one cycle per payload byte, 1-cycle latency from transfer.
  - Low in all other cycles.
  - mem_addr/mem_wdata hold their last values when mem_we=0.
- Address width rules:
  - Address counter is ADDR_W bits.
  - With LEN=0, addresses run 0..255 and the counter wraps to 0 after the last write; no further write occurs.
- Gaps: in_valid low stalls any state with no side effects; state, count and sum are held.
- MAGIC appearing inside DATA or as CHK is treated as ordinary data/checksum, with no resync.
- Memory contents written before a bad checksum remain, but cpu_run stays 0.
- Reset mid-frame: immediate abort to IDLE; a partial program is never run.
- cpu_run never toggles during loading; it is low in every state except RUN.

Test Plan:
1. Assert rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, in_ready=1 after release, cpu_run=0.
2. Send A5,03,20,41,7F,20 back-to-back -> mem writes (0,20),(1,41),(2,7F) each one cycle after transfer; cpu_run=1 and load_done pulses one cycle after the CHK transfer; chk_err=0; in_ready=0.
3. Send A5,03,20,41,7F,21 -> ERR, chk_err=1, cpu_run=0. Then send A5,01,05,FB -> chk_err clears and cpu_run=1 with mem (0,05).
4. Send 00,FF,13 then A5,01,AA,56 with in_valid low for 3 cycles between each byte -> leading bytes discarded; single write (0,AA); RUN reached.
5. Send A5,00, then 256 bytes of 01, then CHK 00 -> 256 writes at addresses 00..FF; sum=00 -> RUN. Pulse reload -> IDLE, cpu_run=0, in_ready=1.
6. Send A5,04,11,22 then pulse rst_n low -> no further mem_we, state IDLE; next A5,01,33,CD loads cleanly to RUN.
